// File: rtl/axil_master_pkg.sv
// Shared types and response codes for the single-outstanding AXI4-Lite initiator.
// The DRAIN state only exists when AXIL_MASTER_TIMEOUT_EN is defined.
package axil_master_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
`ifdef AXIL_MASTER_TIMEOUT_EN
    ,
    DRAIN = 3'd6
`endif
  } state_t;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle with master (m) and slave (s) views.
interface axi4_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport m (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport s (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator driven by a valid/ready command stream.
// Optional B/R timeout with post-timeout drain: define AXIL_MASTER_TIMEOUT_EN.
module axil_master
  import axil_master_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                aclk,
  input  logic                areset,
  axi4_lite_if.m              axi,
  input  logic [31:0]         offset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  // Handshakes on every channel complete when valid & ready are both high at a
  // rising edge; valids are registered and never depend combinationally on a ready.
  localparam int SUM_W = (ADDR_W > 32) ? ADDR_W : 32;

  state_t              state, state_d, state_nat;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                awvalid_q, wvalid_q, arvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          resp_q;
  logic [SUM_W-1:0]    addr_sum;
  logic                cmd_hs, aw_done, w_done, to_fire;

  assign cmd_hs   = (state == IDLE) && cmd_valid;
  assign addr_sum = SUM_W'(cmd_addr) + SUM_W'(offset);
  assign aw_done  = !awvalid_q || axi.awready;
  assign w_done   = !wvalid_q || axi.wready;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             timed_out_q, write_q, counting;

  assign counting = (state == WRITE) || (state == WRESP) || (state == READ) || (state == RDATA);
  assign to_fire  = counting && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && (state_nat == state);
  assign state_d  = to_fire ? RESP : state_nat;
`else
  assign to_fire  = 1'b0;
  assign state_d  = state_nat;
`endif

  always_comb begin
    state_nat = state;
    case (state)
      IDLE:  if (cmd_valid) state_nat = cmd_write ? WRITE : READ;
      WRITE: if (aw_done && w_done) state_nat = WRESP;
      WRESP: if (axi.bvalid) state_nat = RESP;
      READ:  if (axi.arready) state_nat = RDATA;
      RDATA: if (axi.rvalid) state_nat = RESP;
`ifdef AXIL_MASTER_TIMEOUT_EN
      RESP:  if (rsp_ready) state_nat = timed_out_q ? DRAIN : IDLE;
      DRAIN: if (write_q ? axi.bvalid : axi.rvalid) state_nat = IDLE;
`else
      RESP:  if (rsp_ready) state_nat = IDLE;
`endif
      default: state_nat = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      state <= state_d;
      if (cmd_hs) begin
        addr_q    <= addr_sum[ADDR_W-1:0];
        wdata_q   <= cmd_wdata;
        wstrb_q   <= cmd_wstrb;
        awvalid_q <= cmd_write;
        wvalid_q  <= cmd_write;
        arvalid_q <= !cmd_write;
      end else begin
        // Each valid falls only on its own handshake, whatever state we are in.
        if (awvalid_q && axi.awready) awvalid_q <= 1'b0;
        if (wvalid_q && axi.wready)   wvalid_q  <= 1'b0;
        if (arvalid_q && axi.arready) arvalid_q <= 1'b0;
      end
      if (to_fire) begin
        rdata_q <= '0;
        resp_q  <= RESP_TIMEOUT;
      end else if ((state == WRESP) && axi.bvalid) begin
        rdata_q <= '0;
        resp_q  <= axi.bresp;
      end else if ((state == RDATA) && axi.rvalid) begin
        rdata_q <= axi.rdata;
        resp_q  <= axi.rresp;
      end
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      to_cnt      <= '0;
      timed_out_q <= 1'b0;
      write_q     <= 1'b0;
    end else begin
      if (state_d != state) to_cnt <= '0;
      else if (counting)    to_cnt <= to_cnt + 1'b1;
      if (to_fire)                                timed_out_q <= 1'b1;
      else if ((state == DRAIN) && (state_d == IDLE)) timed_out_q <= 1'b0;
      if (cmd_hs) write_q <= cmd_write;
    end
  end

  // After a timeout the late B/R beat is still owed by the slave; accept and discard it.
  assign axi.bready = (state == WRESP) || ((state == DRAIN) && write_q);
  assign axi.rready = (state == RDATA) || ((state == DRAIN) && !write_q);
`else
  assign axi.bready = (state == WRESP);
  assign axi.rready = (state == RDATA);
`endif

  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = addr_q;
  assign axi.awprot  = 3'b000;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = addr_q;
  assign axi.arprot  = 3'b000;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign dbg_state = state;

endmodule
